// File: rtl/regfile_sweep.sv
// Parametrised three-ported register file with a sequential clear sweep.
// Reads are forced to zero until the array has been fully cleared.
module regfile_sweep #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = $clog2(DEPTH),
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             we3,
   input  logic [AW-1:0]    wa3,
   input  logic [WIDTH-1:0] wd3,
   input  logic [AW-1:0]    ra1,
   input  logic [AW-1:0]    ra2,
   output logic [WIDTH-1:0] rd1,
   output logic [WIDTH-1:0] rd2,
   output logic             ready
);

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

   localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   state_t           state_q;
   logic [AW-1:0]    ptr_q;
   logic             ready_q;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             wa_ok;
   logic [AW-1:0]    ra [2];
   logic [WIDTH-1:0] rd [2];

   // A write target must exist and must not be the hardwired zero entry
   assign wa_ok = ({1'b0, wa3} < DEPTH_W) &&
                  !(ZERO_REG && (wa3 == '0));

   // Sweep FSM plus array update; the array itself is never reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_CLEAR;
         ptr_q   <= '0;
         ready_q <= 1'b0;
      end else begin
         unique case (state_q)
            S_CLEAR: begin
               mem_q[ptr_q] <= '0;
               if (ptr_q == LAST) begin
                  state_q <= S_RUN;
                  ready_q <= 1'b1;
                  ptr_q   <= '0;
               end else begin
                  ptr_q <= ptr_q + AW'(1);
               end
            end
            S_RUN: begin
               if (clr) begin
                  state_q <= S_CLEAR;
                  ptr_q   <= '0;
                  ready_q <= 1'b0;
               end else if (we3 && wa_ok) begin
                  mem_q[wa3] <= wd3;
               end
            end
            default: begin
               state_q <= S_CLEAR;
               ptr_q   <= '0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign ra[0] = ra1;
   assign ra[1] = ra2;

   for (genvar p = 0; p < 2; p++) begin : g_rd
      // Read mux: gated by ready, range, zero entry, then bypass
      always_comb begin
         rd[p] = '0;
         if (!ready_q) begin
            rd[p] = '0;
         end else if ({1'b0, ra[p]} >= DEPTH_W) begin
            rd[p] = '0;
         end else if (ZERO_REG && (ra[p] == '0)) begin
            rd[p] = '0;
         end else if (BYPASS && we3 && !clr &&
                      (wa3 == ra[p])) begin
            rd[p] = wd3;
         end else begin
            rd[p] = mem_q[ra[p]];
         end
      end
   end

   assign rd1   = rd[0];
   assign rd2   = rd[1];
   assign ready = ready_q;

endmodule

// File: tb/tb_regfile_sweep.sv
// Scoreboard bench for regfile_sweep: a default instance and a
// small DEPTH=12 instance with no bypass and no zero register.
module tb_regfile_sweep;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Instance A: defaults
   logic        a_reset, a_clr, a_we3;
   logic [4:0]  a_wa3, a_ra1, a_ra2;
   logic [31:0] a_wd3, a_rd1, a_rd2;
   logic        a_ready;

   // Instance B: DEPTH=12, WIDTH=8, ZERO_REG=0, BYPASS=0
   logic        b_reset, b_clr, b_we3;
   logic [3:0]  b_wa3, b_ra1, b_ra2;
   logic [7:0]  b_wd3, b_rd1, b_rd2;
   logic        b_ready;

   regfile_sweep u_a (
      .clk   (clk),
      .reset (a_reset),
      .clr   (a_clr),
      .we3   (a_we3),
      .wa3   (a_wa3),
      .wd3   (a_wd3),
      .ra1   (a_ra1),
      .ra2   (a_ra2),
      .rd1   (a_rd1),
      .rd2   (a_rd2),
      .ready (a_ready)
   );

   regfile_sweep #(
      .WIDTH    (8),
      .DEPTH    (12),
      .ZERO_REG (1'b0),
      .BYPASS   (1'b0)
   ) u_b (
      .clk   (clk),
      .reset (b_reset),
      .clr   (b_clr),
      .we3   (b_we3),
      .wa3   (b_wa3),
      .wd3   (b_wd3),
      .ra1   (b_ra1),
      .ra2   (b_ra2),
      .rd1   (b_rd1),
      .rd2   (b_rd2),
      .ready (b_ready)
   );

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   function automatic void sb_push(input string tag,
                                   input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb_q.push_back(e);
   endfunction

   task automatic sb_pop(input logic [31:0] obs);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("sb_underflow", 32'(sb_q.size()), 32'd1);
      end else begin
         e = sb_q.pop_front();
         check(e.tag, obs, e.v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count edges until ready rises, bounded
   task automatic wait_ready_a(output int n);
      n = 0;
      while (a_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   task automatic wait_ready_b(output int n);
      n = 0;
      while (b_ready !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      a_reset = 1'b0; a_clr = 1'b0; a_we3 = 1'b0;
      a_wa3 = '0; a_wd3 = '0; a_ra1 = '0; a_ra2 = '0;
      b_reset = 1'b0; b_clr = 1'b0; b_we3 = 1'b0;
      b_wa3 = '0; b_wd3 = '0; b_ra1 = '0; b_ra2 = '0;

      // ---------- A: reset and sweep ----------
      repeat (3) tick();
      sb_push("a_rst_ready", 0);
      sb_pop(32'(a_ready));
      a_reset = 1'b1;
      a_we3 = 1'b1; a_wa3 = 5'd9; a_wd3 = 32'hA5;
      a_ra1 = 5'd9; a_ra2 = 5'd9;
      #2;
      sb_push("a_clr_rd1", 0);
      sb_pop(a_rd1);
      wait_ready_a(n);
      a_we3 = 1'b0;
      sb_push("a_sweep_len", 32);
      sb_pop(32'(n));
      for (int a = 0; a < 32; a++) begin
         tick();
         a_ra1 = 5'(a);
         a_ra2 = 5'(31 - a);
         #2;
         sb_push("a_zero_rd1", 0);
         sb_push("a_zero_rd2", 0);
         sb_pop(a_rd1);
         sb_pop(a_rd2);
      end

      // ---------- A: bypass write/read ----------
      tick();
      a_we3 = 1'b1; a_wa3 = 5'd5;
      a_wd3 = 32'hDEADBEEF; a_ra1 = 5'd5;
      #2;
      sb_push("a_byp_pre", 32'hDEADBEEF);
      sb_pop(a_rd1);
      tick();
      a_we3 = 1'b0;
      #2;
      sb_push("a_byp_post", 32'hDEADBEEF);
      sb_pop(a_rd1);

      // ---------- A: zero register ----------
      tick();
      a_we3 = 1'b1; a_wa3 = 5'd0;
      a_wd3 = 32'hFFFFFFFF; a_ra1 = 5'd0;
      #2;
      sb_push("a_zr_pre", 0);
      sb_pop(a_rd1);
      tick();
      a_we3 = 1'b0;
      #2;
      sb_push("a_zr_post", 0);
      sb_pop(a_rd1);

      // ---------- A: dual-port collision ----------
      tick();
      a_we3 = 1'b1; a_wa3 = 5'd9; a_wd3 = 32'hA5;
      a_ra1 = 5'd9; a_ra2 = 5'd9;
      #2;
      sb_push("a_dp_rd1", 32'hA5);
      sb_push("a_dp_rd2", 32'hA5);
      sb_pop(a_rd1);
      sb_pop(a_rd2);
      tick();
      a_we3 = 1'b0;
      #2;
      sb_push("a_dp_post1", 32'hA5);
      sb_push("a_dp_post2", 32'hA5);
      sb_pop(a_rd1);
      sb_pop(a_rd2);

      // ---------- A: clear with simultaneous write ----------
      for (int i = 1; i <= 4; i++) begin
         tick();
         a_we3 = 1'b1; a_wa3 = 5'(i); a_wd3 = 32'(i);
      end
      tick();
      a_we3 = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         tick();
         a_ra1 = 5'(i);
         #2;
         sb_push("a_wr_rd", 32'(i));
         sb_pop(a_rd1);
      end
      tick();
      a_clr = 1'b1; a_we3 = 1'b1;
      a_wa3 = 5'd7; a_wd3 = 32'd9; a_ra1 = 5'd7;
      #2;
      sb_push("a_clr_nobyp", 0);
      sb_pop(a_rd1);
      tick();
      a_clr = 1'b0;
      #2;
      sb_push("a_clr_ready", 0);
      sb_pop(32'(a_ready));
      wait_ready_a(n);
      a_we3 = 1'b0;
      sb_push("a_clr_len", 32);
      sb_pop(32'(n));
      for (int i = 1; i <= 9; i++) begin
         tick();
         a_ra1 = 5'(i);
         #2;
         sb_push("a_clr_rd", 0);
         sb_pop(a_rd1);
      end

      // ---------- A: long clr pulse gives one sweep ----------
      tick();
      a_clr = 1'b1;
      tick();
      tick();
      tick();
      a_clr = 1'b0;
      wait_ready_a(n);
      sb_push("a_pulse_len", 30);
      sb_pop(32'(n));
      tick();
      #2;
      sb_push("a_pulse_once", 1);
      sb_pop(32'(a_ready));

      // ---------- B: reset mid-sweep ----------
      tick();
      b_reset = 1'b1;
      b_we3 = 1'b1; b_wa3 = 4'd3; b_wd3 = 8'h55;
      b_ra1 = 4'd13;
      repeat (5) tick();
      b_reset = 1'b0;
      tick();
      tick();
      sb_push("b_rst_ready", 0);
      sb_pop(32'(b_ready));
      b_reset = 1'b1;
      wait_ready_b(n);
      b_we3 = 1'b0;
      sb_push("b_sweep_len", 12);
      sb_pop(32'(n));
      for (int a = 0; a < 16; a++) begin
         tick();
         b_ra1 = 4'(a);
         b_ra2 = 4'(a);
         #2;
         sb_push("b_zero_rd1", 0);
         sb_push("b_zero_rd2", 0);
         sb_pop(32'(b_rd1));
         sb_pop(32'(b_rd2));
      end

      // ---------- B: out-of-range write ----------
      tick();
      b_we3 = 1'b1; b_wa3 = 4'd13; b_wd3 = 8'h77;
      b_ra1 = 4'd13;
      #2;
      sb_push("b_oor_pre", 0);
      sb_pop(32'(b_rd1));
      tick();
      b_we3 = 1'b0;
      #2;
      sb_push("b_oor_post", 0);
      sb_pop(32'(b_rd1));
      for (int a = 0; a < 12; a++) begin
         tick();
         b_ra1 = 4'(a);
         #2;
         sb_push("b_oor_alias", 0);
         sb_pop(32'(b_rd1));
      end

      // ---------- B: no bypass ----------
      tick();
      b_we3 = 1'b1; b_wa3 = 4'd5; b_wd3 = 8'hEF;
      b_ra1 = 4'd5; b_ra2 = 4'd5;
      #2;
      sb_push("b_nobyp_pre", 0);
      sb_pop(32'(b_rd1));
      tick();
      b_we3 = 1'b0;
      #2;
      sb_push("b_nobyp_rd1", 32'hEF);
      sb_push("b_nobyp_rd2", 32'hEF);
      sb_pop(32'(b_rd1));
      sb_pop(32'(b_rd2));

      // ---------- B: entry 0 is ordinary ----------
      tick();
      b_we3 = 1'b1; b_wa3 = 4'd0; b_wd3 = 8'hFF;
      b_ra1 = 4'd0;
      #2;
      sb_push("b_r0_pre", 0);
      sb_pop(32'(b_rd1));
      tick();
      b_we3 = 1'b0;
      #2;
      sb_push("b_r0_post", 32'hFF);
      sb_pop(32'(b_rd1));

      check("sb_drain", 32'(sb_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_sweep.md
Name: regfile_sweep

Overview:
- Parametrised successor to the single-cycle MIPS three-ported register file: configurable data width and depth, optional hardwired zero register, optional write-to-read bypass.
- Adds a sequential clear engine that zeroes the array one entry per cycle after reset or on request, with a `ready` status output.
- Sits in the datapath as the architectural register file. The controller must hold off register writes until `ready` is 1.

Parameters:
- WIDTH, 32: data width of each entry.
- DEPTH, 32: number of entries; any value ≥2, not required to be a power of two.
- AW, $clog2(DEPTH): address width.
- ZERO_REG, 1: 1 = entry 0 reads as 0 and writes to it are discarded; 0 = entry 0 is an ordinary register.
- BYPASS, 1: 1 = a same-cycle write is forwarded to a matching read port; 0 = reads return the stored value only.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- reset, input, 1: synchronous, active-low reset.
- clr, input, 1: request a full clear sweep; sampled only in RUN.
- we3, input, 1: write enable.
- wa3, input, AW: write address.
- wd3, input, WIDTH: write data.
- ra1, input, AW: read address, port 1.
- ra2, input, AW: read address, port 2.
- rd1, output, WIDTH: read data, port 1; combinational.
- rd2, output, WIDTH: read data, port 2; combinational.
- ready, output, 1: 1 = array valid and writes accepted.

Behaviour:
- **States:** CLEAR and RUN. Internal sweep pointer `ptr` is AW bits wide.
- **Reset.** At each rising edge where `reset`=0: state←CLEAR, ptr←0, ready←0. No array entry is modified while reset is held.
- **CLEAR, each edge with `reset`=1:**
  - entry[ptr]←0.
  - If ptr=DEPTH-1: state←RUN, ready←1, ptr←0.
  - Otherwise: ptr←ptr+1.
  - Sweep length is exactly DEPTH edges. `ready` is first 1 after the DEPTH-th edge following reset release.
- **Inputs during CLEAR:** `we3` and `clr` are ignored; the write is dropped and not queued. `rd1` and `rd2` output 0 regardless of address.
- **RUN, each edge:**
  - If `clr`=1: state←CLEAR, ptr←0, ready←0. A `we3` in the same cycle is dropped (`clr` wins).
  - Otherwise, if we3=1 and wa3<DEPTH and NOT(ZERO_REG and wa3=0): entry[wa3]←wd3.
- **Reads in RUN**, port n (n=1,2) with address `ran`, in priority order:
  1. ran≥DEPTH → 0.
  2. ZERO_REG and ran=0 → 0.
  3. BYPASS and we3 and wa3=ran and clr=0 → wd3.
  4. Otherwise → entry[ran].
- **Read/write timing:**
  - With BYPASS=0, a write becomes visible to reads after the write edge.
  - Both ports may read the same address; both return identical data.
- **Reset mid-sweep:** the sweep restarts from ptr=0 and takes a full DEPTH edges after the next release.
- **`clr` timing:** a `clr` pulse of any length starts exactly one sweep. A `clr` held high re-enters CLEAR on the first RUN edge after each sweep completes.
- **No X propagation:** no entry contents before the first completed sweep may be observed on `rd1`/`rd2`; reads are forced to 0 until `ready`=1.

Test Plan:
- **Reset and sweep.** Defaults; hold reset=0 for 3 cycles, release.
  - `ready`=0 for exactly 32 edges, then 1.
  - Reads of all 32 addresses then return 0.
- **Write/read with bypass.** Defaults, ready=1; we3=1, wa3=5, wd3=32'hDEADBEEF, ra1=5 in the same cycle.
  - rd1=DEADBEEF combinationally before the edge, and still DEADBEEF after it with we3=0.
  - With BYPASS=0, rd1 is 0 before the edge and DEADBEEF after it.
- **Zero register.** Write 32'hFFFFFFFF to wa3=0.
  - ZERO_REG=1: rd1 at ra1=0 stays 0.
  - ZERO_REG=0: rd1 at ra1=0 reads FFFFFFFF.
- **Clear during RUN with simultaneous write.** Entries 1..4 hold 1..4; assert clr=1 with we3=1, wa3=7, wd3=9 in the same cycle.
  - ready=0 for 32 edges, we3 is ignored throughout, and entry 7 reads 0 after the sweep.
- **Reset mid-sweep.** DEPTH=12 (AW=4); release reset, reassert at edge 5, release again.
  - `ready` rises exactly 12 edges after the second release.
  - Address 13 always reads 0, and writes to it are discarded.
- **Dual-port collision.** ra1=ra2=wa3=9, we3=1, wd3=8'hA5.
  - rd1=rd2=A5 with BYPASS=1.
  - A CLEAR-state write to address 9 leaves entry 9 at 0.
